pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined integer add/subtract/compare unit; the next generation of the team's 64-bit CLA adder.
- Carry chain is split into registered stages of CLA segments, so WIDTH can grow without lengthening the critical path.
- Adds a valid/ready handshake, SLT/SLTU modes, result flags and a tag passthrough.
- Sits in the ALU execute path as a multi-cycle functional unit.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of SEG_W*SEGS_PER_STAGE.
- SEG_W, 8, width of one carry-look-ahead segment.
- SEGS_PER_STAGE, 2, CLA segments evaluated per pipeline stage.
- TAG_W, 5, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts when in_valid & in_ready.
- in_op  in  2  0 = ADD, 1 = SUB, 2 = SLT (signed), 3 = SLTU.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_result  out  WIDTH  sum, difference or 0/1 compare result.
- out_cout  out  1  carry out of the MSB.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].
- out_ovf  out  1  signed overflow of the add/sub.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Latency: NST = WIDTH/(SEG_W*SEGS_PER_STAGE) stages. A beat accepted at cycle t shows out_valid at t+NST if unstalled (defaults: NST = 4).
- Throughput: one operation per cycle.
- Subtract datapath: ops 1–3 compute A + ~B + 1 (B XOR all-ones, CIN = 1). ADD uses CIN = 0.
- Carry convention: out_cout = 1 means no borrow.
- Stage k computes bits [k*SW +: SW], where SW = SEG_W*SEGS_PER_STAGE. Inside a stage, CLA segments ripple carries. Each stage registers:
  - its carry out;
  - its partial sum;
  - the not-yet-consumed upper slices of A and B;
  - op, tag and a running zero-AND.
- Overflow: out_ovf = (a_msb == b'_msb) & (sum_msb != a_msb), where b' is the (possibly inverted) B.
- SLT: result = {0…, neg ^ ovf}.
- SLTU: result = {0…, ~cout}.
- For SLT and SLTU, out_cout, out_ovf and out_neg reflect the underlying subtraction. out_zero reflects the final out_result.
- Handshake: each stage has a valid bit. Stage i may load when it is empty or stage i+1 is loading (out_ready for the last stage).
  - in_ready = stage-0 load condition.
  - Bubbles collapse.
  - Outputs hold stable while out_valid & ~out_ready.
- Simultaneous accept and drain while full: allowed; throughput is maintained.
- Reset: all stage valids clear, so out_valid = 0. out_result, out_tag and all out_* flags are 0. in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation: in-flight beats are discarded with no partial output. Datapath registers need not be reset, except that outputs read 0 while out_valid = 0.
- Wrap-around: ADD/SUB results are modulo 2^WIDTH.
  - 0x7FFF…F + 1 gives 0x8000…0 with ovf = 1, cout = 0.
  - 0xFFFF…F + 1 gives 0 with cout = 1, zero = 1.
- No state machine beyond the per-stage valid bits.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined:
  - Adds port in_sat (in, 1), registered through the pipe with the op.
  - For ADD/SUB with in_sat = 1 and ovf = 1, out_result clamps to 0x7FF…F when the true result is positive, or 0x800…0 when negative.
  - out_ovf still reports the overflow; out_zero and out_neg follow the clamped value.
  - SLT/SLTU ignore in_sat.
- Undefined: the port is absent and results always wrap.

Decomposition:
- Package addsub_pkg holds:
  - the 2-bit op typedef with named constants OP_ADD, OP_SUB, OP_SLT, OP_SLTU;
  - a helper constant function computing NST.
- One sub-module, addsub_pipe_stage (parameters SEG_W, SEGS_PER_STAGE): combinational SW-bit slice adder with carry-in/out and slice-zero. Instantiated NST times by a generate loop.
- Pipeline registers and handshake live in the top.

Test Plan:
- ADD 0x0000_0000_0000_0005 + 0x0000_0000_0000_0003, out_ready = 1 → after 4 cycles result = 8, cout = 0, zero = 0, ovf = 0, tag echoed.
- SUB 5 − 5 → result = 0, zero = 1, cout = 1. ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → result = 0x8000_0000_0000_0000, ovf = 1, neg = 1.
- SLT A = 0xFFFF_FFFF_FFFF_FFFF (−1), B = 1 → result = 1. SLTU with the same operands → result = 0.
- Back-to-back 8 ops with out_ready low for cycles 3–6 → in_ready drops once all 4 stages are full. No loss or duplication; results leave in order with matching tags. Outputs stable while stalled.
- Reset asserted with 3 ops in flight → next cycle out_valid = 0 and outputs = 0. No stale result appears afterwards. First new op completes in 4 cycles.
- With ADDSUB_SATURATE_EN:
  - in_sat = 1, ADD 0x7FFF_FFFF_FFFF_FFFF + 0x10 → result = 0x7FFF_FFFF_FFFF_FFFF, ovf = 1.
  - in_sat = 1, SUB 0x8000_0000_0000_0000 − 1 → result = 0x8000_0000_0000_0000.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract/compare unit.
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_SLT  = 2'd2,
      OP_SLTU = 2'd3
   } op_t;

   function automatic int calc_nst(input int width, input int seg_w, input int segs_per_stage);
      return width / (seg_w * segs_per_stage);
   endfunction

endpackage

// File: rtl/addsub_pipe_stage.sv
// Combinational slice adder: SEGS_PER_STAGE look-ahead segments of SEG_W bits,
// carries ripple between segments. Also reports whether the slice sum is zero.
module addsub_pipe_stage #(
   parameter int SEG_W          = 8,
   parameter int SEGS_PER_STAGE = 2
)(
   input  logic [SEG_W*SEGS_PER_STAGE-1:0] a,
   input  logic [SEG_W*SEGS_PER_STAGE-1:0] b,
   input  logic                            cin,
   output logic [SEG_W*SEGS_PER_STAGE-1:0] sum,
   output logic                            cout,
   output logic                            zero
);
   localparam int SW = SEG_W * SEGS_PER_STAGE;

   logic [SW-1:0]           g;
   logic [SW-1:0]           p;
   logic [SW-1:0]           c;
   logic [SEGS_PER_STAGE:0] cseg;

   assign g = a & b;
   assign p = a ^ b;

   // Each bit's carry is expanded from the segment carry-in on its own (look-ahead
   // form); only the segment carries chain from one segment to the next.
   always_comb begin
      logic acc;
      int   base;
      c       = '0;
      cseg    = '0;
      acc     = 1'b0;
      base    = 0;
      cseg[0] = cin;
      for (int s = 0; s < SEGS_PER_STAGE; s++) begin
         base = s * SEG_W;
         for (int i = 0; i < SEG_W; i++) begin
            acc = cseg[s];
            for (int j = 0; j < i; j++) begin
               acc = g[base+j] | (p[base+j] & acc);
            end
            c[base+i] = acc;
         end
         cseg[s+1] = g[base+SEG_W-1] | (p[base+SEG_W-1] & c[base+SEG_W-1]);
      end
   end

   assign sum  = p ^ c;
   assign cout = cseg[SEGS_PER_STAGE];
   assign zero = ~|sum;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub/compare unit: one SW-bit carry slice per registered stage,
// valid/ready handshake with collapsing bubbles. ADDSUB_SATURATE_EN adds in_sat.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH          = 64,
   parameter int SEG_W          = 8,
   parameter int SEGS_PER_STAGE = 2,
   parameter int TAG_W          = 5
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
`ifdef ADDSUB_SATURATE_EN
   input  logic             in_sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);
   localparam int SW  = SEG_W * SEGS_PER_STAGE;
   localparam int NST = calc_nst(WIDTH, SEG_W, SEGS_PER_STAGE);

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [NST-1:0] vld;
   logic [NST:0]   ld;
   logic           sat_in;

`ifdef ADDSUB_SATURATE_EN
   assign sat_in = in_sat;
`else
   assign sat_in = 1'b0;
`endif

   // A stage loads when empty or when its successor is loading, so bubbles collapse.
   always_comb begin
      ld      = '0;
      ld[NST] = out_ready;
      for (int k = NST - 1; k >= 0; k--) begin
         ld[k] = ~vld[k] | ld[k+1];
      end
   end

   assign in_ready = ld[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else begin
         if (ld[0]) vld[0] <= in_valid;
         for (int k = 1; k < NST; k++) begin
            if (ld[k]) vld[k] <= vld[k-1];
         end
      end
   end

   for (genvar k = 0; k < NST; k++) begin : g_st
      localparam int AW = WIDTH - k*SW;
      localparam int PW = (k+1) * SW;

      logic [AW-1:0]    a_all;
      logic [AW-1:0]    b_all;
      logic [PW-1:0]    s_acc;
      logic [SW-1:0]    bx;
      logic [SW-1:0]    s_sl;
      op_t              op_s;
      logic [TAG_W-1:0] tag_s;
      logic             sat_s;
      logic             z_s;
      logic             cin;
      logic             inv;
      logic             co_sl;
      logic             z_sl;

      if (k == 0) begin : g_src
         assign a_all = in_a;
         assign b_all = in_b;
         assign op_s  = op_t'(in_op);
         assign tag_s = in_tag;
         assign sat_s = sat_in;
         assign z_s   = 1'b1;
         assign cin   = inv;
         assign s_acc = s_sl;
      end else begin : g_src
         assign a_all = g_st[k-1].g_reg.a_rem;
         assign b_all = g_st[k-1].g_reg.b_rem;
         assign op_s  = g_st[k-1].g_reg.op_q;
         assign tag_s = g_st[k-1].g_reg.tag_q;
         assign sat_s = g_st[k-1].g_reg.sat_q;
         assign z_s   = g_st[k-1].g_reg.z_q;
         assign cin   = g_st[k-1].g_reg.cy_q;
         assign s_acc = {s_sl, g_st[k-1].g_reg.s_q};
      end

      assign inv = (op_s != OP_ADD);
      assign bx  = b_all[SW-1:0] ^ {SW{inv}};

      addsub_pipe_stage #(
         .SEG_W          (SEG_W),
         .SEGS_PER_STAGE (SEGS_PER_STAGE)
      ) u_slice (
         .a    (a_all[SW-1:0]),
         .b    (bx),
         .cin  (cin),
         .sum  (s_sl),
         .cout (co_sl),
         .zero (z_sl)
      );

      if (k < NST - 1) begin : g_reg
         logic [AW-SW-1:0] a_rem;
         logic [AW-SW-1:0] b_rem;
         logic [PW-1:0]    s_q;
         logic             cy_q;
         logic             z_q;
         logic             sat_q;
         op_t              op_q;
         logic [TAG_W-1:0] tag_q;

         always_ff @(posedge clk) begin
            if (ld[k]) begin
               a_rem <= a_all[AW-1:SW];
               b_rem <= b_all[AW-1:SW];
               s_q   <= s_acc;
               cy_q  <= co_sl;
               z_q   <= z_s & z_sl;
               sat_q <= sat_s;
               op_q  <= op_s;
               tag_q <= tag_s;
            end
         end
      end else begin : g_out
         logic [WIDTH-1:0] res;
         logic             ovf;
         logic             neg;
         logic             zero;
         logic [WIDTH-1:0] res_q;
         logic             cout_q;
         logic             zero_q;
         logic             neg_q;
         logic             ovf_q;
         logic [TAG_W-1:0] tag_q;

         always_comb begin
            res  = s_acc;
            ovf  = (a_all[SW-1] == bx[SW-1]) & (s_acc[WIDTH-1] != a_all[SW-1]);
            neg  = s_acc[WIDTH-1];
            zero = z_s & z_sl;
            case (op_s)
               OP_SLT: begin
                  res  = {{(WIDTH-1){1'b0}}, s_acc[WIDTH-1] ^ ovf};
                  zero = ~res[0];
               end
               OP_SLTU: begin
                  res  = {{(WIDTH-1){1'b0}}, ~co_sl};
                  zero = ~res[0];
               end
               default: begin
                  // On overflow both operands share a sign, which is the true result's sign.
                  if (sat_s & ovf) begin
                     res  = a_all[SW-1] ? SAT_MIN : SAT_MAX;
                     neg  = a_all[SW-1];
                     zero = 1'b0;
                  end
               end
            endcase
         end

         always_ff @(posedge clk) begin
            if (ld[k]) begin
               res_q  <= res;
               cout_q <= co_sl;
               zero_q <= zero;
               neg_q  <= neg;
               ovf_q  <= ovf;
               tag_q  <= tag_s;
            end
         end
      end
   end

   assign out_valid  = vld[NST-1];
   assign out_result = g_st[NST-1].g_out.res_q & {WIDTH{out_valid}};
   assign out_cout   = g_st[NST-1].g_out.cout_q & out_valid;
   assign out_zero   = g_st[NST-1].g_out.zero_q & out_valid;
   assign out_neg    = g_st[NST-1].g_out.neg_q  & out_valid;
   assign out_ovf    = g_st[NST-1].g_out.ovf_q  & out_valid;
   assign out_tag    = g_st[NST-1].g_out.tag_q  & {TAG_W{out_valid}};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (64-bit default build; saturation
// cases are exercised when ADDSUB_SATURATE_EN is defined).
module tb_pipelined_addsub;
   localparam int W  = 64;
   localparam int TW = 5;
   localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_op = 2'd0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [TW-1:0] in_tag = '0;
`ifdef ADDSUB_SATURATE_EN
   logic          in_sat = 1'b0;
`endif
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_result;
   logic          out_cout, out_zero, out_neg, out_ovf;
   logic [TW-1:0] out_tag;

   pipelined_addsub #(.WIDTH(W), .SEG_W(8), .SEGS_PER_STAGE(2), .TAG_W(TW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
`ifdef ADDSUB_SATURATE_EN
      .in_sat     (in_sat),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_ovf    (out_ovf),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic        cout;
      logic        zero;
      logic        neg;
      logic        ovf;
      logic [4:0]  tag;
   } exp_t;

   exp_t q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   bit   saw_not_ready = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: exact signed/unsigned arithmetic on the mathematical values.
   function automatic exp_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [4:0] tag, input logic sat);
      exp_t              e;
      logic signed [65:0] sa, sb, tr;
      logic [64:0]        u;
      sa = $signed({{2{a[63]}}, a});
      sb = $signed({{2{b[63]}}, b});
      tr = (op == 2'd0) ? sa + sb : sa - sb;
      u  = (op == 2'd0) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
      e.ovf  = (tr > SMAX) || (tr < SMIN);
      e.cout = (op == 2'd0) ? u[64] : (a >= b);
      e.res  = u[63:0];
      e.neg  = u[63];
      if (op == 2'd2)      e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      else if (op == 2'd3) e.res = (a < b) ? 64'd1 : 64'd0;
      else if (sat && e.ovf) begin
         e.res = (tr < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
         e.neg = e.res[63];
      end
      e.zero = (e.res == 64'd0);
      e.tag  = tag;
      return e;
   endfunction

   logic [63:0] snap_res;
   logic [4:0]  snap_tag;
   logic [3:0]  snap_fl;
   bit          stalled = 0;

   always @(negedge clk) begin
      exp_t e;
      logic sat_eff;
`ifdef ADDSUB_SATURATE_EN
      sat_eff = in_sat;
`else
      sat_eff = 1'b0;
`endif
      if (reset) begin
         q.delete();
         stalled = 0;
      end else begin
         if (stalled) begin
            chk("stall_hold_result", out_result, snap_res);
            chk("stall_hold_tag", out_tag, snap_tag);
            chk("stall_hold_flags", {out_valid, out_cout, out_zero, out_neg, out_ovf}, {1'b1, snap_fl});
         end
         if (out_valid) begin
            chk("output_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q[0];
               chk("result", out_result, e.res);
               chk("cout", out_cout, e.cout);
               chk("zero", out_zero, e.zero);
               chk("neg", out_neg, e.neg);
               chk("ovf", out_ovf, e.ovf);
               chk("tag", out_tag, e.tag);
               if (out_ready) void'(q.pop_front());
            end
         end else begin
            chk("idle_outputs_zero", {out_result, out_tag, out_cout, out_zero, out_neg, out_ovf} == '0, 1);
         end
         stalled  = out_valid && !out_ready;
         snap_res = out_result;
         snap_tag = out_tag;
         snap_fl  = {out_cout, out_zero, out_neg, out_ovf};
         if (in_valid && !in_ready) saw_not_ready = 1;
         if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_tag, sat_eff));
      end
   end

   task automatic run_one(input string nm, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, input logic [63:0] er, input logic ec, input logic ez,
                          input logic en, input logic eo);
      int n;
      in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, n, 4);
      chk({nm, "_result"}, out_result, er);
      chk({nm, "_cout"}, out_cout, ec);
      chk({nm, "_zero"}, out_zero, ez);
      chk({nm, "_neg"}, out_neg, en);
      chk({nm, "_ovf"}, out_ovf, eo);
      chk({nm, "_tag"}, out_tag, tag);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
      bit acc = 0;
      int n = 0;
      in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      chk("send_accepted", acc, 1);
   endtask

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 6))
         0:       return 64'd0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h7FFF_FFFF_FFFF_FFFF;
         3:       return 64'h8000_0000_0000_0000;
         4:       return {32'd0, 24'd0, 8'($urandom)};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, total=%0d passed=%0d", total_cnt, pass_cnt);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t m;
      int   sent;
      int   n;
      bit   acc;

      // The reference model itself, pinned by hand-computed values.
      m = model(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 1'b0);
      chk("model_add_ovf", {m.res, 60'd0, m.ovf, m.cout, m.neg, m.zero}, {64'h8000_0000_0000_0000, 60'd0, 4'b1010});
      m = model(2'd1, 64'd3, 64'd5, 5'd0, 1'b0);
      chk("model_sub_borrow", {m.res, 62'd0, m.cout, m.ovf}, {64'hFFFF_FFFF_FFFF_FFFE, 64'd0});

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_outputs", {out_result, out_tag, out_cout, out_zero, out_neg, out_ovf} == '0, 1);
      reset = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);

      run_one("add_5_3",    2'd0, 64'd5, 64'd3, 5'd17, 64'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      run_one("sub_5_5",    2'd1, 64'd5, 64'd5, 5'd3,  64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      run_one("add_maxpos", 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd9,
              64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
      run_one("add_wrap",   2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd30, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      run_one("slt_m1_1",   2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4,  64'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      run_one("sltu_m1_1",  2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5,  64'd0, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
      in_sat = 1'b1;
      run_one("sat_add", 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h10, 5'd6,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      run_one("sat_sub", 2'd1, 64'h8000_0000_0000_0000, 64'd1, 5'd7,
              64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
      in_sat = 1'b0;
`endif

      // Back-to-back burst with the consumer stalled for four cycles.
      saw_not_ready = 0;
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) send(2'($urandom), rnd64(), rnd64(), 5'(i + 8));
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("burst_in_ready_dropped", saw_not_ready, 1);
      chk("burst_drained", q.size(), 0);

      // Reset with three operations in flight.
      send(2'd0, 64'd1, 64'd2, 5'd21);
      send(2'd1, 64'd9, 64'd4, 5'd22);
      send(2'd0, 64'd7, 64'd7, 5'd23);
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_outputs", {out_result, out_tag, out_cout, out_zero, out_neg, out_ovf} == '0, 1);
      reset = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         chk("post_reset_no_stale", out_valid, 0);
      end
      run_one("after_reset", 2'd0, 64'd100, 64'd23, 5'd11, 64'd123, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic with random gaps and back-pressure.
      sent = 0;
      for (int cyc = 0; cyc < 4000 && sent < 400; cyc++) begin
         if (!in_valid && ($urandom_range(0, 3) != 0)) begin
            in_op    = 2'($urandom);
            in_a     = rnd64();
            in_b     = rnd64();
            in_tag   = 5'($urandom);
`ifdef ADDSUB_SATURATE_EN
            in_sat   = 1'($urandom);
`endif
            in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            in_valid = 1'b0;
            sent++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("random_all_sent", sent, 400);
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("final_queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
